// File: rtl/df_pkg.sv
// Shared definitions for the direct form filter front end: loader state
// encoding and the unity default coefficient helper.
package df_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2
  } loader_state_e;

  // Unity coefficient 2^q; callers truncate to their coefficient width.
  function automatic logic [63:0] df_unity_coeff(input int unsigned q);
    return 64'd1 << q;
  endfunction

endpackage

// File: rtl/df_coeff_bank.sv
// N+1 entry coefficient register bank with a single-tap write port and a
// load-all port; resets to a unity passthrough set (tap 0 = 2^Q).
module df_coeff_bank
  import df_pkg::*;
#(
  parameter int N           = 3,
  parameter int COEFF_WIDTH = 16,
  parameter int Q           = 14,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [COEFF_WIDTH-1:0]       wr_data_i,
  input  logic                         load_i,
  input  logic [COEFF_WIDTH*(N+1)-1:0] load_data_i,
  output logic [COEFF_WIDTH*(N+1)-1:0] taps_o
);

  localparam int BW = COEFF_WIDTH * (N + 1);
  localparam logic [BW-1:0] RESET_TAPS = BW'(COEFF_WIDTH'(df_unity_coeff(Q)));

  logic [BW-1:0] taps_q, taps_d;

  always_comb begin
    // NOTE: default assignment first so no path leaves taps_d unassigned (no latch).
    taps_d = taps_q;
    if (load_i) begin
      taps_d = load_data_i;
    end else if (wr_en_i) begin
      // Out-of-range addresses match no tap and are silently dropped here.
      for (int t = 0; t <= N; t++) begin
        if (wr_addr_i == ADDR_WIDTH'(t)) taps_d[COEFF_WIDTH*t +: COEFF_WIDTH] = wr_data_i;
      end
    end
  end

  // NOTE: the bank is a handful of flops, not a RAM, so it is reset to a defined set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) taps_q <= RESET_TAPS;
    else     taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/df_coeff_loader.sv
// Coefficient loader: stages taps in a shadow bank and commits them atomically
// on a sample strobe. Optional readback port enabled by DF_COEFF_READBACK_EN.
module df_coeff_loader
  import df_pkg::*;
#(
  parameter int N           = 3,
  parameter int COEFF_WIDTH = 16,
  parameter int Q           = 14,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  input  logic                         wr_last,
  input  logic                         sample_strobe,
  input  logic                         err_clr,
`ifdef DF_COEFF_READBACK_EN
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [COEFF_WIDTH-1:0]       rd_data,
`endif
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_coeffs,
  output logic                         coeff_update,
  output logic                         pending,
  output logic                         err
);

  localparam int BW = COEFF_WIDTH * (N + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(N);

  loader_state_e state_q;
  logic          wr_ready_q, pending_q, coeff_update_q, err_q;
  logic          wr_accept, addr_oob, commit;
  logic [BW-1:0] shadow_taps;

  assign wr_accept = wr_valid & wr_ready_q;
  assign addr_oob  = wr_addr > MAX_ADDR;
  assign commit    = (state_q == ST_PENDING) & sample_strobe;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_ready_q     <= 1'b1;
      pending_q      <= 1'b0;
      coeff_update_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      coeff_update_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (wr_accept) begin
            if (wr_last) begin
              state_q    <= ST_PENDING;
              wr_ready_q <= 1'b0;
              pending_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_PENDING: begin
          if (sample_strobe) begin
            state_q        <= ST_IDLE;
            wr_ready_q     <= 1'b1;
            pending_q      <= 1'b0;
            coeff_update_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          wr_ready_q <= 1'b1;
          pending_q  <= 1'b0;
        end
      endcase
      // A new error outranks a simultaneous clear.
      if (wr_accept && addr_oob) err_q <= 1'b1;
      else if (err_clr)          err_q <= 1'b0;
    end
  end

  df_coeff_bank #(
    .N(N), .COEFF_WIDTH(COEFF_WIDTH), .Q(Q), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_accept),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .load_i      (1'b0),
    .load_data_i ({BW{1'b0}}),
    .taps_o      (shadow_taps)
  );

  df_coeff_bank #(
    .N(N), .COEFF_WIDTH(COEFF_WIDTH), .Q(Q), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_active (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (1'b0),
    .wr_addr_i   ({ADDR_WIDTH{1'b0}}),
    .wr_data_i   ({COEFF_WIDTH{1'b0}}),
    .load_i      (commit),
    .load_data_i (shadow_taps),
    .taps_o      (packed_coeffs)
  );

`ifdef DF_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= '0;
      for (int t = 0; t <= N; t++) begin
        if (rd_addr == ADDR_WIDTH'(t)) rd_data_q <= shadow_taps[COEFF_WIDTH*t +: COEFF_WIDTH];
      end
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign wr_ready     = wr_ready_q;
  assign pending      = pending_q;
  assign coeff_update = coeff_update_q;
  assign err          = err_q;

endmodule
